permutation_controller: RTL

Sequencer for the single-round ASCON permutation datapath (state mux, constant addition, substitution, diffusion, enabled state register). It accepts a start request for either p12 (pa, rounds 0..11) or p6 (pb, rounds 6..11), then drives the datapath's mux select, register enable and 4-bit round index every cycle until the last round is captured. It signals completion with a one-cycle done pulse. It sits directly upstream of the permutation datapath, between it and the top-level ASCON-128 mode FSM.

---
 rtl/ascon_pack.sv | 16 +
 rtl/permutation_controller_round_counter.sv | 38 +++
 rtl/permutation_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/ascon_pack.sv
// ascon_pack: shared constants and types for the ASCON permutation sequencer.
//   ROUND_FIRST_PA / ROUND_FIRST_PB : first round index of p12 / p6
//   ROUND_LAST                      : index of the final round of both variants
//   type_perm_fsm                   : sequencer FSM state encoding
package ascon_pack;

    localparam logic [3:0] ROUND_FIRST_PA = 4'd0;
    localparam logic [3:0] ROUND_FIRST_PB = 4'd6;
    localparam logic [3:0] ROUND_LAST     = 4'd11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } type_perm_fsm;

endpackage

// File: rtl/permutation_controller_round_counter.sv
// permutation_controller_round_counter: 4-bit round index register.
// Ports:
//   clock_i    in  clock
//   resetb_i   in  synchronous active-low clear
//   load_i     in  load load_val_i (has priority over inc_i)
//   load_val_i in  value to load
//   inc_i      in  increment by one
//   round_o    out current count
//   is_last_o  out count >= ROUND_LAST (12..15 also count as last so a
//                  corrupted counter can never trap the FSM in RUN)
module permutation_controller_round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       inc_i,
    output logic [3:0] round_o,
    output logic       is_last_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign round_o   = cnt_q;
    assign is_last_o = (cnt_q >= ROUND_LAST);

endmodule

// File: rtl/permutation_controller.sv
// permutation_controller: round sequencer for the single-round ASCON
// permutation datapath. Runs p12 (rounds 0..11) or p6 (rounds 6..11).
// Ports:
//   clock_i      in   clock, rising edge
//   resetb_i     in   synchronous active-low reset; forces all outputs low
//   start_i      in   permutation request, accepted only in IDLE
//   mode_i       in   0 = p12, 1 = p6 (sampled in the acceptance cycle)
//   sel_o        out  datapath mux: 0 = external state, 1 = feedback
//   en_o         out  datapath state-register enable
//   round_o      out  round index for constant addition
//   busy_o       out  permutation in progress (RUN)
//   done_o       out  registered one-cycle completion pulse
//   perm_count_o out  saturating count of completed permutations
//                     (only when ASCON_PERM_CNT_EN is defined)
module permutation_controller
    import ascon_pack::*;
(
    input  logic        clock_i,
    input  logic        resetb_i,
    input  logic        start_i,
    input  logic        mode_i,
    output logic        sel_o,
    output logic        en_o,
    output logic [3:0]  round_o,
    output logic        busy_o,
`ifdef ASCON_PERM_CNT_EN
    output logic [15:0] perm_count_o,
`endif
    output logic        done_o
);

    type_perm_fsm state_q, state_d;
    logic         done_q, done_d;
    logic         cnt_load, cnt_inc, cnt_last;
    logic [3:0]   cnt_val, cnt_load_val;

    // The acceptance cycle already computes the first round, so RUN starts
    // one past it.
    assign cnt_load_val = mode_i ? (ROUND_FIRST_PB + 4'd1) : (ROUND_FIRST_PA + 4'd1);

    permutation_controller_round_counter u_round_counter (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .inc_i      (cnt_inc),
        .round_o    (cnt_val),
        .is_last_o  (cnt_last)
    );

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        sel_o    = 1'b0;
        en_o     = 1'b0;
        round_o  = 4'd0;
        busy_o   = 1'b0;
        case (state_q)
            IDLE: begin
                round_o = mode_i ? ROUND_FIRST_PB : ROUND_FIRST_PA;
                en_o    = start_i;
                if (start_i) begin
                    cnt_load = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sel_o   = 1'b1;
                en_o    = 1'b1;
                busy_o  = 1'b1;
                round_o = cnt_val;
                if (cnt_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset is synchronous, so the outputs must be masked for the whole
        // time it is held low, not only after the first edge.
        if (!resetb_i) begin
            sel_o   = 1'b0;
            en_o    = 1'b0;
            round_o = 4'd0;
            busy_o  = 1'b0;
        end
    end

    assign done_o = done_q & resetb_i;

`ifdef ASCON_PERM_CNT_EN
    logic [15:0] perm_count_q;

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            perm_count_q <= 16'd0;
        end else if (done_q && (perm_count_q != 16'hFFFF)) begin
            perm_count_q <= perm_count_q + 16'd1;
        end
    end

    assign perm_count_o = perm_count_q;
`endif

endmodule
